// File: rtl/pl_mem_wb.sv
// pl_mem_wb: memory/write-back stage with req/ack data-memory port, register-file write and flags.
// Optional MEM_TIMEOUT_EN adds an ack timeout that aborts the transaction and sets sticky mem_err.
module pl_mem_wb #(
    parameter int NUM_DOMAINS = 1,
    parameter int ADDR_WID    = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:6]               ex_ctrl,
    input  logic [NUM_DOMAINS*8-1:0] ex_result,
    input  logic [2:0]               ex_dest,
    input  logic [ADDR_WID-1:0]      ex_wr_addr,
    input  logic [ADDR_WID-1:0]      ex_rd_addr,
    input  logic [0:4]               ex_branch_conds,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WID-1:0]      mem_addr,
    output logic [NUM_DOMAINS*8-1:0] mem_wdata,
    input  logic                     mem_ack,
    input  logic [NUM_DOMAINS*8-1:0] mem_rdata,
    output logic                     rf_wr_en,
    output logic [2:0]               rf_wr_addr,
    output logic [NUM_DOMAINS*8-1:0] rf_wr_data,
    output logic                     flag_carry,
    output logic                     flag_gt,
    output logic                     flag_lt,
    output logic                     flag_eq,
    output logic                     stall,
    output logic                     mem_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state, state_d;
    logic live, do_st, do_ld, done, tmo;
    logic [2:0] ld_dest;
    logic unused_ok;
    assign unused_ok = ^{ex_ctrl[5], ex_ctrl[6], TIMEOUT_CYC != 0};
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign tmo = (state != IDLE) && !mem_ack && (cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif
    assign stall = (state != IDLE);
    always_comb begin
        live    = (state == IDLE) && !ex_ctrl[3];
        do_st   = live && ex_ctrl[0];
        do_ld   = live && ex_ctrl[4] && !ex_ctrl[0];
        done    = (state != IDLE) && (mem_ack || tmo);
        state_d = do_st ? WR_WAIT : do_ld ? RD_WAIT : done ? IDLE : state;
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ld_dest    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            flag_carry <= 1'b0;
            flag_gt    <= 1'b0;
            flag_lt    <= 1'b0;
            flag_eq    <= 1'b0;
        end else begin
            rf_wr_en <= 1'b0;
            if (do_st || do_ld) begin
                mem_req  <= 1'b1;
                mem_we   <= do_st;
                mem_addr <= do_st ? ex_wr_addr : ex_rd_addr;
            end
            if (do_st) mem_wdata <= ex_result;
            if (do_ld) ld_dest <= ex_dest;
            if (done) mem_req <= 1'b0;
            if (live && !ex_ctrl[0] && !ex_ctrl[4] && ex_ctrl[1]) begin
                rf_wr_en   <= 1'b1;
                rf_wr_addr <= ex_dest;
                rf_wr_data <= ex_result;
            end else if (state == RD_WAIT && mem_ack) begin
                rf_wr_en   <= 1'b1;
                rf_wr_addr <= ld_dest;
                rf_wr_data <= mem_rdata;
            end
            if (live && ex_branch_conds[4]) begin
                flag_gt <= ex_branch_conds[0];
                flag_lt <= ex_branch_conds[1];
                flag_eq <= ex_branch_conds[2];
            end
            if (live && ex_ctrl[2]) flag_carry <= ex_branch_conds[3];
        end
    end
`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        cnt     <= (reset || state == IDLE) ? '0 : cnt + 1'b1;
        mem_err <= !reset && (mem_err || tmo);
    end
`else
    assign mem_err = 1'b0;
`endif
endmodule

// File: doc/pl_mem_wb.md
Name: pl_mem_wb

Overview:
Memory/write-back stage that consumes the EX-stage pipeline outputs: the control vector, result, destination, memory addresses and branch conditions.
- Issues data-memory reads and writes over a req/ack handshake and stalls upstream while a transaction is outstanding.
- Writes ALU and load results to the register file.
- Holds the architectural flags (carry, gt, lt, eq) used by later branches.

Parameters:
NUM_DOMAINS, 1, number of 8-bit RNS domains carried per datum
ADDR_WID, 16, data-memory address width
TIMEOUT_CYC, 64, ack timeout in cycles (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_ctrl  in  [0:6]  {store_to_mem, reg_wr_en, save_cout, invalidate_execute_instr, load_true, invalidate_fetch_instr, invalidate_decode_instr}; bits 5,6 ignored
ex_result  in  NUM_DOMAINS*8  operation result; store data for stores
ex_dest  in  3  destination register address
ex_wr_addr  in  ADDR_WID  store address
ex_rd_addr  in  ADDR_WID  load address
ex_branch_conds  in  [0:4]  {gt, lt, eq, carry, compare_true}
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WID  memory address
mem_wdata  out  NUM_DOMAINS*8  write data
mem_ack  in  1  memory acknowledge
mem_rdata  in  NUM_DOMAINS*8  read data, valid with mem_ack
rf_wr_en  out  1  register-file write strobe
rf_wr_addr  out  3  register-file write address
rf_wr_data  out  NUM_DOMAINS*8  register-file write data
flag_carry, flag_gt, flag_lt, flag_eq  out  1 each  architectural flags
stall  out  1  upstream must hold its outputs
mem_err  out  1  sticky timeout error

Behaviour:
- Live instruction = ex_ctrl[3]==0, sampled while state==IDLE. Inputs presented while stall=1 are not consumed.
- FSM states: IDLE, RD_WAIT, WR_WAIT. stall = (state != IDLE), combinational from registered state.
- IDLE, live store (ex_ctrl[0]):
  - Next cycle: mem_req=1, mem_we=1, mem_addr=ex_wr_addr, mem_wdata=ex_result.
  - Go to WR_WAIT. No register-file write.
- IDLE, live load (ex_ctrl[4]), no store:
  - Next cycle: mem_req=1, mem_we=0, mem_addr=ex_rd_addr, dest captured.
  - Go to RD_WAIT.
- Store and load both set: store wins; load ignored.
- IDLE, live non-memory instruction with reg_wr_en: rf_wr_en=1 next cycle (1-cycle latency), rf_wr_addr=ex_dest, rf_wr_data=ex_result.
- WR_WAIT / RD_WAIT:
  - mem_req and all memory outputs held stable until mem_ack is sampled high; the earliest ack is the cycle after mem_req rises.
  - On ack: mem_req=0 next cycle, return to IDLE.
  - RD_WAIT additionally registers mem_rdata; rf_wr_en=1 next cycle with the captured dest.
  - The held upstream instruction is consumed in that first IDLE cycle.
- mem_ack while IDLE is ignored.
- rf_wr_en is a single-cycle pulse; otherwise rf_wr_en=0 and addr/data hold their last values.
- Flags, updated only by live instructions:
  - compare_true (bit 4) loads gt/lt/eq from bits 0..2.
  - save_cout (ex_ctrl[2]) loads flag_carry from bit 3.
  - Update takes effect the next cycle; unrelated flags are retained.
- Reset (any state, including mid-transaction): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0; all flags 0; mem_err=0. An outstanding load produces no write-back.
- Multi-domain: data paths are treated as opaque NUM_DOMAINS*8 vectors; no per-domain arithmetic.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WR_WAIT/RD_WAIT and increments each wait cycle.
  - When it reaches TIMEOUT_CYC without ack: drop mem_req, return to IDLE, suppress the load write-back, set mem_err=1 (sticky until reset).
  - An ack in the same cycle as timeout counts as a success.
- Undefined: the FSM waits indefinitely and mem_err is tied 0.

Test Plan:
- ALU write: ex_ctrl=0100000, ex_dest=3, ex_result=0x5A -> next cycle rf_wr_en=1, rf_wr_addr=3, rf_wr_data=0x5A; stall stays 0.
- Load, ack 3 cycles after req: load, ex_rd_addr=0x0123, dest=5, rdata=0xC3 -> stall=1 and mem_req held with addr 0x0123, we=0 for 3 cycles; the cycle after ack: rf_wr_en=1, addr 5, data 0xC3, stall=0.
- Store then ALU op presented during the wait: store addr 0x0040, data 0x11 -> mem_we=1, mem_wdata=0x11; the ALU op is held and written only in the cycle after IDLE resumes; no rf write for the store.
- Flags: compare with conds=10001 -> gt=1, lt=0, eq=0, carry unchanged. Same conds with invalidate bit set -> flags unchanged.
- Reset in RD_WAIT: assert reset before ack -> mem_req=0 next cycle, stall=0, no rf_wr_en, flags 0; a subsequent late ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> mem_req drops after 4 wait cycles, mem_err=1, no write-back.
